// File: rtl/mpt_pkg.sv
// Shared types and parameter legality limits for the MPT memory responder.
package mpt_pkg;

  typedef struct packed {
    logic [63:0] rdata;
    logic        error;
  } mpt_rsp_t;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 4;
  localparam int unsigned OUT_MAX_MIN = 2;
  localparam int unsigned DEPTH_MIN   = 2;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mpt_rsp_fifo.sv
// Response FIFO: power-of-two depth, pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module mpt_rsp_fifo
  import mpt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push,
  input  logic     pop,
  input  mpt_rsp_t wdata,
  output mpt_rsp_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  mpt_rsp_t    store [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) store[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = store[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mpt_mem_responder.sv
// Table-memory responder for the page walker: fixed-latency, in-order responses.
// Optional MPT_RESP_RANGE_CHECK_EN flags addresses outside the table window.
module mpt_mem_responder
  import mpt_pkg::*;
#(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned OUT_MAX   = 4,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  output logic        mem_gnt_o,
  input  logic [63:0] mem_addr_i,
  input  logic        mem_we_i,
  input  logic [7:0]  mem_be_i,
  input  logic [63:0] mem_wdata_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [63:0] mem_rdata_o,
  output logic        mem_error_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(OUT_MAX + 1);
  localparam logic [CW-1:0] OUT_MAX_C = CW'(OUT_MAX);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX || OUT_MAX < OUT_MAX_MIN ||
      !is_pow2(OUT_MAX) || DEPTH < DEPTH_MIN || !is_pow2(DEPTH)) begin : g_bad_param
    $error("mpt_mem_responder: illegal DEPTH/LATENCY/OUT_MAX");
  end

  logic          active;
  logic [CW-1:0] outstanding;
  logic          accept;
  logic          pop;
  logic [63:0]   offset;
  logic [IW-1:0] idx;
  logic          misaligned;
  logic          out_of_range;
  logic          err;
  mpt_rsp_t      acc_rsp;
  logic          push;
  mpt_rsp_t      push_rsp;
  mpt_rsp_t      head_rsp;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_bits;

  logic [63:0] mem [DEPTH];

  // active keeps the grant low through reset and raises it one clock later
  assign mem_gnt_o = active && (outstanding < OUT_MAX_C);
  assign accept    = mem_req_i && mem_gnt_o;
  assign pop       = mem_valid_o && mem_ready_i;

  assign offset     = mem_addr_i - BASE_ADDR;
  assign idx        = offset[IW+2:3];
  assign misaligned = |mem_addr_i[2:0];

`ifdef MPT_RESP_RANGE_CHECK_EN
  assign out_of_range = (mem_addr_i < BASE_ADDR) || (offset[63:IW+3] != '0);
`else
  assign out_of_range = 1'b0;
`endif

  assign err         = misaligned || out_of_range;
  assign unused_bits = ^{offset[63:IW+3], offset[2:0], fifo_full};

  always_comb begin
    acc_rsp.error = err;
    acc_rsp.rdata = (err || mem_we_i) ? 64'h0 : mem[idx];
  end

  always_ff @(posedge clk_i) begin
    if (accept && mem_we_i && !err) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_be_i[b]) mem[idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active      <= 1'b0;
      outstanding <= '0;
    end else begin
      active <= 1'b1;
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // The FIFO write is the last latency stage, so only LATENCY-1 registers sit in front of it.
  if (LATENCY == 1) begin : g_direct
    assign push     = accept;
    assign push_rsp = acc_rsp;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld;
    mpt_rsp_t           rsp [LATENCY-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld <= '0;
      end else begin
        vld[0] <= accept;
        for (int i = 1; i < int'(LATENCY) - 1; i++) vld[i] <= vld[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      rsp[0] <= acc_rsp;
      for (int i = 1; i < int'(LATENCY) - 1; i++) rsp[i] <= rsp[i-1];
    end

    assign push     = vld[LATENCY-2];
    assign push_rsp = rsp[LATENCY-2];
  end

  mpt_rsp_fifo #(
    .DEPTH (OUT_MAX)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  (push_rsp),
    .rdata  (head_rsp),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign mem_valid_o = !fifo_empty;
  assign mem_rdata_o = mem_valid_o ? head_rsp.rdata : 64'h0;
  assign mem_error_o = mem_valid_o && head_rsp.error;

endmodule

// File: tb/tb_mpt_mem_responder.sv
// Self-checking bench for mpt_mem_responder: queue-based reference model plus directed literal checks.
module tb_mpt_mem_responder;

  localparam int unsigned DEPTH     = 512;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned OUT_MAX   = 4;
  localparam logic [63:0] BASE_ADDR = 64'h0;
  localparam int          WIN       = 16;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic        mem_req_i   = 1'b0;
  logic        mem_gnt_o;
  logic [63:0] mem_addr_i  = '0;
  logic        mem_we_i    = 1'b0;
  logic [7:0]  mem_be_i    = '0;
  logic [63:0] mem_wdata_i = '0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b1;
  logic [63:0] mem_rdata_o;
  logic        mem_error_o;

  always #5 clk_i = ~clk_i;

  mpt_mem_responder #(
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY),
    .OUT_MAX   (OUT_MAX),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mem_req_i   (mem_req_i),
    .mem_gnt_o   (mem_gnt_o),
    .mem_addr_i  (mem_addr_i),
    .mem_we_i    (mem_we_i),
    .mem_be_i    (mem_be_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_error_o (mem_error_o)
  );

  typedef struct {
    int          acc;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] log_rdata[$];
  logic        log_err[$];
  int          log_lat[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          head_first = -1;
  bit          gnt_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_idx(input logic [63:0] a);
    logic [63:0] w;
    w = (a - BASE_ADDR) >> 3;
    return int'(w % 64'(DEPTH));
  endfunction

  function automatic logic ref_err(input logic [63:0] a);
    logic e;
    e = (a[2:0] != 3'b000);
`ifdef MPT_RESP_RANGE_CHECK_EN
    if (a < BASE_ADDR || a >= BASE_ADDR + 64'(DEPTH) * 64'd8) e = 1'b1;
`endif
    return e;
  endfunction

  // Reference model: a response is visible once LATENCY cycles have passed since
  // acceptance and all older responses have been consumed.
  initial begin : compare
    exp_t e;
    logic ev;
    logic eg;
    int   ix;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        check("rst_gnt",   64'(mem_gnt_o),   64'(0));
        check("rst_valid", 64'(mem_valid_o), 64'(0));
        check("rst_rdata", mem_rdata_o,      64'(0));
        check("rst_error", 64'(mem_error_o), 64'(0));
        exp_q.delete();
        head_first = -1;
        gnt_ready  = 1'b0;
      end else begin
        eg = gnt_ready && (exp_q.size() < OUT_MAX);
        check("gnt", 64'(mem_gnt_o), 64'(eg));
        ev = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + int'(LATENCY));
        check("valid", 64'(mem_valid_o), 64'(ev));
        if (ev) begin
          check("rdata", mem_rdata_o, exp_q[0].rdata);
          check("error", 64'(mem_error_o), 64'(exp_q[0].err));
        end
        if (mem_valid_o && head_first < 0) head_first = cyc;
        if (ev && mem_ready_i) begin
          log_rdata.push_back(mem_rdata_o);
          log_err.push_back(mem_error_o);
          log_lat.push_back(head_first - exp_q[0].acc);
          void'(exp_q.pop_front());
          head_first = -1;
        end
        if (mem_req_i && eg) begin
          e.acc   = cyc;
          e.err   = ref_err(mem_addr_i);
          ix      = ref_idx(mem_addr_i);
          e.rdata = (e.err || mem_we_i) ? 64'h0 : ref_mem[ix];
          if (!e.err && mem_we_i) begin
            for (int b = 0; b < 8; b++)
              if (mem_be_i[b]) ref_mem[ix][8*b +: 8] = mem_wdata_i[8*b +: 8];
          end
          exp_q.push_back(e);
        end
        gnt_ready = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [63:0] a, input logic we, input logic [7:0] be,
                       input logic [63:0] wd);
    bit done;
    done        = 1'b0;
    mem_addr_i  = a;
    mem_we_i    = we;
    mem_be_i    = be;
    mem_wdata_i = wd;
    mem_req_i   = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      done = mem_gnt_o;
      step();
    end
    mem_req_i = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: addr %h never granted", a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
    end
    step();
  endtask

  task automatic chk_log(input string name, input int k, input logic [63:0] d, input logic er);
    if (k < log_rdata.size()) begin
      check({name, "_data"}, log_rdata[k], d);
      check({name, "_err"}, 64'(log_err[k]), 64'(er));
    end else begin
      tests++;
      fails++;
      $display("FAIL %s_missing: got %0d responses expected more than %0d", name, log_rdata.size(), k);
    end
  endtask

  task automatic rd_check(input string name, input logic [63:0] a, input logic [63:0] d,
                          input logic er);
    int n0;
    n0 = log_rdata.size();
    issue(a, 1'b0, 8'h00, 64'h0);
    drain();
    chk_log(name, n0, d, er);
  endtask

  initial begin : stim
    logic [63:0] snap [5];
    int          grants;
    logic        g5;
    int          n0;
    int          r;
    int          k;
    int          stale;

    rst_ni      = 1'b0;
    mem_ready_i = 1'b1;
    repeat (3) step();
    rst_ni = 1'b1;
    step();
    check("gnt_after_reset", 64'(mem_gnt_o), 64'(1));
    step();

    for (int i = 0; i < WIN; i++)
      issue(BASE_ADDR + 64'(i * 8), 1'b1, 8'hFF, {$urandom, $urandom});
    drain();

    // full-word write then readback, two-cycle latency
    n0 = log_rdata.size();
    issue(64'h40, 1'b1, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    issue(64'h40, 1'b0, 8'h00, 64'h0);
    drain();
    chk_log("wr40", n0, 64'h0, 1'b0);
    chk_log("rd40", n0 + 1, 64'hDEADBEEF_CAFEF00D, 1'b0);
    if (n0 + 1 < log_lat.size()) check("rd40_latency", 64'(log_lat[n0+1]), 64'(2));

    // partial write under byte enables
    issue(64'h40, 1'b1, 8'h0F, 64'hFFFFFFFF_11111111);
    drain();
    rd_check("rd40_be", 64'h40, 64'hDEADBEEF_11111111, 1'b0);

    // back-pressure: OUT_MAX grants then stall
    for (int i = 0; i < 5; i++) snap[i] = ref_mem[i];
    mem_ready_i = 1'b0;
    grants = 0;
    g5 = 1'b1;
    n0 = log_rdata.size();
    for (int i = 0; i < 5; i++) begin
      mem_req_i  = 1'b1;
      mem_we_i   = 1'b0;
      mem_be_i   = 8'h00;
      mem_addr_i = 64'(i * 8);
      if (mem_gnt_o) grants++;
      if (i == 4) g5 = mem_gnt_o;
      step();
    end
    check("bp_grants", 64'(grants), 64'(4));
    check("bp_gnt5", 64'(g5), 64'(0));
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    check("bp_gnt_after_pop", 64'(mem_gnt_o), 64'(1));
    step();
    mem_req_i   = 1'b0;
    mem_ready_i = 1'b1;
    drain();
    for (int i = 0; i < 5; i++) chk_log("bp_order", n0 + i, snap[i], 1'b0);

    // misaligned accesses
    rd_check("rd44", 64'h44, 64'h0, 1'b1);
    n0 = log_rdata.size();
    issue(64'h44, 1'b1, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
    drain();
    chk_log("wr44", n0, 64'h0, 1'b1);
    rd_check("rd40_after44", 64'h40, 64'hDEADBEEF_11111111, 1'b0);

    // beyond the table window
    issue(64'h0, 1'b1, 8'hFF, 64'h01234567_89ABCDEF);
    drain();
`ifdef MPT_RESP_RANGE_CHECK_EN
    rd_check("rd1000", 64'h1000, 64'h0, 1'b1);
`else
    rd_check("rd1000", 64'h1000, 64'h01234567_89ABCDEF, 1'b0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r           = int'($urandom_range(0, 99));
      k           = int'($urandom_range(0, WIN - 1));
      mem_req_i   = ($urandom_range(0, 99) < 60);
      mem_we_i    = 1'($urandom_range(0, 1));
      mem_be_i    = 8'($urandom);
      mem_wdata_i = {$urandom, $urandom};
      mem_addr_i  = BASE_ADDR + 64'(k * 8);
      if (r < 10)      mem_addr_i[2:0] = 3'($urandom_range(1, 7));
      else if (r < 20) mem_addr_i = mem_addr_i + 64'h1000;
      mem_ready_i = ($urandom_range(0, 99) < 70);
      step();
    end
    mem_req_i   = 1'b0;
    mem_ready_i = 1'b1;
    drain();

    // reset with requests in flight
    issue(64'h48, 1'b1, 8'hFF, 64'h5555AAAA_12345678);
    issue(64'h40, 1'b1, 8'hFF, 64'hDEADBEEF_11111111);
    drain();
    mem_ready_i = 1'b0;
    issue(64'h40, 1'b0, 8'h00, 64'h0);
    issue(64'h48, 1'b0, 8'h00, 64'h0);
    issue(64'h50, 1'b0, 8'h00, 64'h0);
    check("pre_rst_outstanding", 64'(exp_q.size()), 64'(3));
    rst_ni = 1'b0;
    step();
    check("rst_valid_next", 64'(mem_valid_o), 64'(0));
    step();
    rst_ni      = 1'b1;
    mem_ready_i = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_valid_o) stale++;
      step();
    end
    check("no_stale_rsp", 64'(stale), 64'(0));
    rd_check("rd48_after_rst", 64'h48, 64'h5555AAAA_12345678, 1'b0);
    rd_check("rd40_after_rst", 64'h40, 64'hDEADBEEF_11111111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
